// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: pointer comparison used to derive the full flag.
package fifo_pkg;

  // Full when the wrap bits differ and the address bits match; n is the address width.
  function automatic logic ptr_full(input logic [31:0] w, input logic [31:0] r,
                                    input int unsigned n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    return (w[n] != r[n]) && ((w & mask) == (r & mask));
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// N+1-bit FIFO pointer with wrap bit; the Gray output is kept for a future dual-clock variant.
module fifo_ptr #(
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_inc,
  output logic [N:0] o_bin,
  output logic [N:0] o_gray
);

  logic [N:0] r_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + (N+1)'(1);
    end
  end

  assign o_bin  = r_ptr;
  assign o_gray = r_ptr ^ (r_ptr >> 1);

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO, 2^N x W, with registered-state full/empty flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] in,
  input  logic         put,
  output logic         full,
  output logic [W-1:0] out,
  input  logic         get,
  output logic         empty
);

  localparam int DEPTH = 1 << N;

  logic [N:0]   w_wptr;
  logic [N:0]   w_rptr;
  logic [N:0]   w_wgray;
  logic [N:0]   w_rgray;
  logic         w_put_ok;
  logic         w_get_ok;
  logic [W-1:0] r_mem [DEPTH];

  // Requests are qualified by the pre-edge flags only, so put and get never interact.
  assign w_put_ok = put && !full;
  assign w_get_ok = get && !empty;

  fifo_ptr #(.N(N)) u_wptr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_put_ok),
    .o_bin   (w_wptr),
    .o_gray  (w_wgray)
  );

  fifo_ptr #(.N(N)) u_rptr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_get_ok),
    .o_bin   (w_rptr),
    .o_gray  (w_rgray)
  );

  // Gray coding is a bijection, so equal Gray pointers mean equal binary pointers.
  assign empty = (w_wgray == w_rgray);
  assign full  = ptr_full(32'(w_wptr), 32'(w_rptr), unsigned'(N));

  // NOTE: the memory is reset on purpose so that out reads 0 while reset is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_put_ok) begin
      r_mem[w_wptr[N-1:0]] <= in;
    end
  end

  assign out = r_mem[w_rptr[N-1:0]];

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, fill/overflow, underflow, streaming, simultaneous ops, mid-run reset.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       put = 1'b0;
  logic       get = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       full;
  logic       empty;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] q[$];

  sync_fifo #(.W(8), .N(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (d_in),
    .put     (put),
    .full    (full),
    .out     (d_out),
    .get     (get),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; the queue model decides acceptance from pre-edge occupancy.
  task automatic step(input logic p, input logic g, input logic [7:0] d, input string tag);
    bit acc_put;
    bit acc_get;
    @(negedge clk);
    put  = p;
    get  = g;
    d_in = d;
    acc_put = p && (q.size() < 8);
    acc_get = g && (q.size() > 0);
    @(posedge clk);
    if (acc_get) void'(q.pop_front());
    if (acc_put) q.push_back(d);
    #1;
    check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(q.size() == 8));
    if (q.size() > 0) check({tag, "_out"}, 32'(d_out), 32'(q[0]));
  endtask

  initial begin
    int   wr;
    int   rd;
    int   fulls;
    logic prev_full;

    // Reset held with put asserted: nothing may be written.
    reset_n = 1'b0;
    put     = 1'b1;
    d_in    = 8'h99;
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_out", 32'(d_out), 32'h00);
    @(negedge clk);
    put = 1'b0;
    #2 reset_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 8'h00, "idle");
    check("idle_empty", 32'(empty), 32'd1);

    // Fill to full, then an ignored overflow put.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i), "fill");
    check("fill_full", 32'(full), 32'd1);
    step(1'b1, 1'b0, 8'hAA, "ovf");
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_head", 32'(d_out), 32'h00);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", 32'(d_out), 32'(i));
      step(1'b0, 1'b1, 8'h00, "drain");
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Underflow is ignored; a later put appears on the next cycle.
    step(1'b0, 1'b1, 8'h00, "udf");
    check("udf_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b0, 8'h5C, "udf_put");
    check("udf_out", 32'(d_out), 32'h5C);
    check("udf_nempty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 8'h00, "udf_pop");
    check("udf_pop_empty", 32'(empty), 32'd1);

    // Streaming: writer 2-in-3, reader 1-in-2 once 6 bytes are in.
    wr = 0;
    rd = 0;
    fulls = 0;
    prev_full = 1'b0;
    for (int c = 0; c < 300 && rd < 18; c++) begin
      logic p;
      logic g;
      bit   pa;
      p  = (c % 3 != 2) && (wr < 18);
      g  = (wr >= 6) && (c % 2 == 1);
      pa = p && (q.size() < 8);
      if (g && q.size() > 0) begin
        check("stream_order", 32'(d_out), 32'(rd));
        rd++;
      end
      step(p, g, 8'(wr), "stream");
      if (pa) wr++;
      if (full && !prev_full) fulls++;
      prev_full = full;
    end
    check("stream_done", 32'(rd), 32'd18);
    check("stream_full_seen", 32'(fulls > 0), 32'd1);
    step(1'b0, 1'b0, 8'h00, "stream_end");
    check("stream_empty", 32'(empty), 32'd1);

    // Simultaneous put and get while full: only the get happens.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i), "sf_fill");
    step(1'b1, 1'b1, 8'hEE, "sf_both");
    check("sf_full_drop", 32'(full), 32'd0);
    check("sf_head", 32'(d_out), 32'h21);
    for (int i = 0; i < 7; i++) begin
      check("sf_order", 32'(d_out), 32'(8'h21 + i));
      step(1'b0, 1'b1, 8'h00, "sf_drain");
    end
    check("sf_empty", 32'(empty), 32'd1);

    // Simultaneous put and get at 4 entries: occupancy and order kept.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h10 + i), "hf_fill");
    step(1'b1, 1'b1, 8'h14, "hf_both");
    check("hf_head", 32'(d_out), 32'h11);
    for (int i = 0; i < 4; i++) begin
      check("hf_order", 32'(d_out), 32'(8'h11 + i));
      step(1'b0, 1'b1, 8'h00, "hf_drain");
    end
    check("hf_empty", 32'(empty), 32'd1);

    // Reset between edges with 5 entries queued.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i), "mr_fill");
    check("mr_nempty", 32'(empty), 32'd0);
    @(negedge clk);
    put = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mr_empty", 32'(empty), 32'd1);
    check("mr_full", 32'(full), 32'd0);
    check("mr_out", 32'(d_out), 32'h00);
    q.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
    step(1'b1, 1'b0, 8'h77, "mr_put");
    check("mr_put_out", 32'(d_out), 32'h77);
    step(1'b0, 1'b1, 8'h00, "mr_pop");
    check("mr_pop_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
